// File: rtl/bolme_hakem.sv
// bolme_hakem: round-robin arbiter/sequencer in front of one shared sequential
// signed Q4.4 divider core.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_gecerli/req_hazir    per-requester valid / one-hot accept pulse
//   req_bolunen, req_bolen   packed 8-bit operands, slot i = [8i+7:8i]
//   resp_*                   response channel (valid/ready, id, quotient,
//                            remainder, error flag)
//   div_basla/div_bitti      start/done handshake with the divider core
//   div_bolunen, div_bolen   operands held for the core for the whole operation
//   div_bolum, div_kalan     core results, valid while div_bitti is high
//   div_sifirla              core reset request (reset and timeout recovery)
module bolme_hakem #(
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int ZAMAN_ASIMI = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_gecerli,
  input  logic [8*NREQ-1:0]    req_bolunen,
  input  logic [8*NREQ-1:0]    req_bolen,
  output logic [NREQ-1:0]      req_hazir,
  output logic                 resp_gecerli,
  input  logic                 resp_hazir,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_bolum,
  output logic [15:0]          resp_kalan,
  output logic                 resp_hata,
  output logic                 div_basla,
  output logic [7:0]           div_bolunen,
  output logic [7:0]           div_bolen,
  input  logic                 div_bitti,
  input  logic [15:0]          div_bolum,
  input  logic [15:0]          div_kalan,
  output logic                 div_sifirla
);

  localparam int CW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;

  typedef enum logic [1:0] {BOS, YUKLE, BEKLE, CEVAP} durum_t;

  durum_t         durum_q;
  logic [IDW-1:0] son_q;
  logic [CW-1:0]  sayac_q;

  logic           resp_gecerli_q;
  logic [IDW-1:0] resp_id_q;
  logic [15:0]    resp_bolum_q;
  logic [15:0]    resp_kalan_q;
  logic           resp_hata_q;
  logic           div_basla_q;
  logic [7:0]     div_bolunen_q;
  logic [7:0]     div_bolen_q;
  logic           div_sifirla_q;

  // Round-robin pick: first valid index strictly above son_q, otherwise
  // wrap and take the first valid index from 0 up to son_q.
  logic           gnt_var;
  logic [IDW-1:0] gnt_idx;
  logic [7:0]     sec_a;
  logic [7:0]     sec_b;

  always_comb begin
    gnt_var = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_var && req_gecerli[i] && (IDW'(i) > son_q)) begin
        gnt_var = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_var && req_gecerli[i] && (IDW'(i) <= son_q)) begin
        gnt_var = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

  always_comb begin
    sec_a = '0;
    sec_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sec_a = req_bolunen[8*i +: 8];
        sec_b = req_bolen[8*i +: 8];
      end
    end
  end

  // The accept pulse has to land in the same cycle the request is seen, so it
  // is the only combinational output; everything else comes from registers.
  always_comb begin
    req_hazir = '0;
    if (durum_q == BOS && gnt_var) req_hazir[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q        <= BOS;
      son_q          <= IDW'(NREQ-1);
      sayac_q        <= '0;
      resp_gecerli_q <= 1'b0;
      resp_id_q      <= '0;
      resp_bolum_q   <= '0;
      resp_kalan_q   <= '0;
      resp_hata_q    <= 1'b0;
      div_basla_q    <= 1'b0;
      div_bolunen_q  <= '0;
      div_bolen_q    <= '0;
      div_sifirla_q  <= 1'b1;
    end else begin
      div_basla_q   <= 1'b0;
      div_sifirla_q <= 1'b0;
      case (durum_q)
        BOS: begin
          if (gnt_var) begin
            son_q     <= gnt_idx;
            resp_id_q <= gnt_idx;
            if (sec_b == 8'h00) begin
              // Divide-by-zero never reaches the core: saturate toward the
              // dividend's sign and answer straight away.
              resp_bolum_q   <= sec_a[7] ? 16'h8000 : 16'h7FFF;
              resp_kalan_q   <= '0;
              resp_hata_q    <= 1'b1;
              resp_gecerli_q <= 1'b1;
              durum_q        <= CEVAP;
            end else begin
              div_bolunen_q <= sec_a;
              div_bolen_q   <= sec_b;
              div_basla_q   <= 1'b1;   // high during YUKLE
              durum_q       <= YUKLE;
            end
          end
        end
        YUKLE: begin
          sayac_q <= '0;
          durum_q <= BEKLE;
        end
        BEKLE: begin
          // done is checked first so it wins over a coincident timeout
          if (div_bitti) begin
            resp_bolum_q   <= div_bolum;
            resp_kalan_q   <= div_kalan;
            resp_hata_q    <= 1'b0;
            resp_gecerli_q <= 1'b1;
            durum_q        <= CEVAP;
          end else if (sayac_q == CW'(ZAMAN_ASIMI-1)) begin
            div_sifirla_q  <= 1'b1;
            resp_bolum_q   <= '0;
            resp_kalan_q   <= '0;
            resp_hata_q    <= 1'b1;
            resp_gecerli_q <= 1'b1;
            durum_q        <= CEVAP;
          end else begin
            sayac_q <= sayac_q + CW'(1);
          end
        end
        CEVAP: begin
          if (resp_hazir) begin
            resp_gecerli_q <= 1'b0;
            durum_q        <= BOS;
          end
        end
        default: durum_q <= BOS;
      endcase
    end
  end

  assign resp_gecerli = resp_gecerli_q;
  assign resp_id      = resp_id_q;
  assign resp_bolum   = resp_bolum_q;
  assign resp_kalan   = resp_kalan_q;
  assign resp_hata    = resp_hata_q;
  assign div_basla    = div_basla_q;
  assign div_bolunen  = div_bolunen_q;
  assign div_bolen    = div_bolen_q;
  assign div_sifirla  = div_sifirla_q;

endmodule

// File: tb/tb_bolme_hakem.sv
// Bench for bolme_hakem: stub divider core, requester agents and a
// transaction-level reference model checked every cycle.
module tb_bolme_hakem;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int ZA   = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_gecerli;
  logic [8*NREQ-1:0]   req_bolunen, req_bolen;
  logic [NREQ-1:0]     req_hazir;
  logic                resp_gecerli, resp_hazir;
  logic [IDW-1:0]      resp_id;
  logic [15:0]         resp_bolum, resp_kalan;
  logic                resp_hata;
  logic                div_basla;
  logic [7:0]          div_bolunen, div_bolen;
  logic                div_bitti;
  logic [15:0]         div_bolum, div_kalan;
  logic                div_sifirla;

  always #5 clk = ~clk;

  bolme_hakem #(.NREQ(NREQ), .IDW(IDW), .ZAMAN_ASIMI(ZA)) dut (
    .clk(clk), .rst(rst),
    .req_gecerli(req_gecerli), .req_bolunen(req_bolunen), .req_bolen(req_bolen),
    .req_hazir(req_hazir),
    .resp_gecerli(resp_gecerli), .resp_hazir(resp_hazir), .resp_id(resp_id),
    .resp_bolum(resp_bolum), .resp_kalan(resp_kalan), .resp_hata(resp_hata),
    .div_basla(div_basla), .div_bolunen(div_bolunen), .div_bolen(div_bolen),
    .div_bitti(div_bitti), .div_bolum(div_bolum), .div_kalan(div_kalan),
    .div_sifirla(div_sifirla)
  );

  int checks = 0, failures = 0;

  // requester agents
  logic [NREQ-1:0] pend;
  logic [7:0]      ra [NREQ];
  logic [7:0]      rb [NREQ];
  bit rand_req = 0, hold_all = 0;
  int rdy_mode = 1;               // 0 low, 1 high, 2 random

  // stub core
  int  stub_cnt = 0, stub_lat = 4;
  bit  stub_never = 0, rand_lat = 0, fix_en = 0, inject_late = 0;
  logic [15:0] fix_q = '0, fix_r = '0;
  logic [7:0]  sa = '0, sb = '0;

  // reference model
  int  cyc = 0, son = NREQ-1, b_cyc = 0, resp_at = -1, sif_at = -1;
  bit  busy = 0, waiting = 0, basla_due = 0, sif_rel = 0;
  int  exp_id = 0;
  logic [15:0] exp_q, exp_r;
  logic        exp_h;
  logic [7:0]  ga, gb;
  int  gq[$];
  int  served = 0, sif_cnt = 0, hs_cyc = -10, last_gap = 0, stall = 0;
  int  lr_id;
  logic [15:0] lr_q, lr_r;
  logic        lr_h;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core stand-in result; operand passthrough shows up in the answer.
  function automatic logic [31:0] stub_res(input logic [7:0] a, input logic [7:0] b);
    if (fix_en) return {fix_q, fix_r};
    return {a, b, b, a};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int s);
    for (int k = 1; k <= NREQ; k++)
      if (v[(s + k) % NREQ]) return (s + k) % NREQ;
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_bolunen[8*i +: 8] = ra[i];
      req_bolen[8*i +: 8]   = rb[i];
    end
    req_gecerli = pend;
  endtask

  task automatic req(input int i, input logic [7:0] a, input logic [7:0] b);
    pend[i] = 1'b1; ra[i] = a; rb[i] = b;
    apply();
  endtask

  task automatic model_reset();
    busy = 0; waiting = 0; basla_due = 0; son = NREQ-1; resp_at = -1; sif_at = -1;
  endtask

  task automatic observe();
    int g;
    logic [NREQ-1:0] oh;
    bit exp_v;
    @(negedge clk);
    cyc++;
    // core side
    chk("div_basla", div_basla, basla_due);
    basla_due = 0;
    if (div_basla) begin
      chk("div_bolunen", div_bolunen, ga);
      chk("div_bolen", div_bolen, gb);
      waiting = 1; b_cyc = cyc; sa = div_bolunen; sb = div_bolen;
      stub_cnt = stub_never ? 0 : (rand_lat ? int'($urandom_range(1, 12)) : stub_lat);
    end else if (waiting) begin
      chk("div_hold_a", div_bolunen, ga);
      chk("div_hold_b", div_bolen, gb);
      if (div_bitti) begin
        {exp_q, exp_r} = stub_res(ga, gb); exp_h = 0; resp_at = cyc + 1; waiting = 0;
      end else if (cyc == b_cyc + ZA) begin
        exp_q = 0; exp_r = 0; exp_h = 1; resp_at = cyc + 1; sif_at = cyc + 1; waiting = 0;
      end
    end
    chk("div_sifirla", div_sifirla, (sif_rel || cyc == sif_at));
    if (div_sifirla && !sif_rel) begin
      sif_cnt++;
      if (inject_late) begin stub_cnt = 3; inject_late = 0; end
    end
    sif_rel = 0;
    // grant side
    if (busy) chk("grant_busy", req_hazir, 0);
    else begin
      g = rr_pick(req_gecerli, son);
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      chk("grant", req_hazir, oh);
      if (g >= 0) begin
        busy = 1; son = g; exp_id = g; pend[g] = 1'b0; gq.push_back(g);
        last_gap = cyc - hs_cyc;
        ga = req_bolunen[8*g +: 8]; gb = req_bolen[8*g +: 8];
        if (gb == 8'h00) begin
          exp_q = ga[7] ? 16'h8000 : 16'h7FFF; exp_r = 0; exp_h = 1; resp_at = cyc + 1;
        end else basla_due = 1;
      end
    end
    // response side
    exp_v = busy && resp_at >= 0 && cyc >= resp_at;
    chk("resp_gecerli", resp_gecerli, exp_v);
    if (exp_v && resp_gecerli) begin
      chk("resp_id", resp_id, exp_id);
      chk("resp_bolum", resp_bolum, exp_q);
      chk("resp_kalan", resp_kalan, exp_r);
      chk("resp_hata", resp_hata, exp_h);
      if (resp_hazir) begin
        busy = 0; resp_at = -1; served++; hs_cyc = cyc;
        lr_id = resp_id; lr_q = resp_bolum; lr_r = resp_kalan; lr_h = resp_hata;
      end else stall++;
    end
  endtask

  task automatic drive();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hold_all && !pend[i]) begin
        pend[i] = 1'b1; ra[i] = 8'($urandom); rb[i] = 8'($urandom_range(1, 255));
      end else if (rand_req) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1; ra[i] = 8'($urandom);
          rb[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
      end
    end
    apply();
    resp_hazir = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    div_bitti = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        div_bitti = 1'b1;
        {div_bolum, div_kalan} = stub_res(sa, sb);
      end
    end
  endtask

  task automatic tick();
    observe();
    drive();
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    do begin tick(); n++; end
    while ((busy || waiting || pend != 0 || stub_cnt > 0) && n < maxc);
    chk("wait_bound", n < maxc, 1);
  endtask

  initial begin
    int n, base, s0, f0;
    rst = 1'b1; pend = '0; resp_hazir = 1'b1;
    div_bitti = 1'b0; div_bolum = '0; div_kalan = '0;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    apply();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_hazir", req_hazir, 0);
    chk("rst_resp_gecerli", resp_gecerli, 0);
    chk("rst_resp_bolum", resp_bolum, 0);
    chk("rst_resp_hata", resp_hata, 0);
    chk("rst_div_basla", div_basla, 0);
    chk("rst_div_sifirla", div_sifirla, 1);
    rst = 1'b0; sif_rel = 1;

    // fairness: everyone requests continuously
    hold_all = 1; stub_lat = 2;
    for (int i = 0; i < NREQ; i++) req(i, 8'(16 * i + 1), 8'(i + 1));
    n = 0;
    while (gq.size() < 6 && n < 200) begin tick(); n++; end
    hold_all = 0;
    chk("t2_bound", n < 200, 1);
    for (int k = 0; k < 6; k++) chk("t2_order", (k < gq.size()) ? gq[k] : -1, k % 4);
    wait_idle(300);

    // single request, fixed core answer after 10 cycles
    fix_en = 1; fix_q = 16'h0020; fix_r = 16'h0000; stub_lat = 10;
    req(0, 8'h30, 8'h18);
    wait_idle(100);
    chk("t1_id", lr_id, 0); chk("t1_bolum", lr_q, 16'h0020);
    chk("t1_kalan", lr_r, 0); chk("t1_hata", lr_h, 0);
    fix_en = 0;

    // divide by zero, both signs
    req(2, 8'hE0, 8'h00);
    wait_idle(50);
    chk("t3_id", lr_id, 2); chk("t3_bolum_neg", lr_q, 16'h8000);
    chk("t3_kalan", lr_r, 0); chk("t3_hata", lr_h, 1);
    req(2, 8'h20, 8'h00);
    wait_idle(50);
    chk("t3_bolum_pos", lr_q, 16'h7FFF);

    // timeout, then a late done that must be ignored
    stub_never = 1; inject_late = 1; s0 = served; f0 = sif_cnt;
    req(1, 8'h40, 8'h20);
    wait_idle(300);
    chk("t4_hata", lr_h, 1); chk("t4_bolum", lr_q, 0); chk("t4_kalan", lr_r, 0);
    chk("t4_sif_pulses", sif_cnt - f0, 1);
    chk("t4_one_resp", served - s0, 1);
    stub_never = 0;

    // done on the exact timeout cycle wins
    stub_lat = ZA;
    req(3, 8'h11, 8'h22);
    wait_idle(300);
    chk("t4b_hata", lr_h, 0); chk("t4b_bolum", lr_q, 16'h1122); chk("t4b_kalan", lr_r, 16'h2211);

    // backpressure with req 1 waiting
    rdy_mode = 0; stub_lat = 3; stall = 0;
    req(0, 8'h10, 8'h08);
    n = 0;
    while (!resp_gecerli && n < 50) begin tick(); n++; end
    req(1, 8'h55, 8'h05);
    repeat (5) tick();
    rdy_mode = 1;
    wait_idle(100);
    chk("t5_stall", stall >= 5, 1);
    chk("t5_grant1", gq[$], 1);
    chk("t5_gap", last_gap, 1);

    // reset while waiting on the core
    stub_lat = 30;
    req(2, 8'h44, 8'h11);
    n = 0;
    while (!(waiting && cyc > b_cyc + 5) && n < 50) begin tick(); n++; end
    chk("t6_reach", n < 50, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_resp_gecerli", resp_gecerli, 0);
    chk("t6_div_sifirla", div_sifirla, 1);
    chk("t6_div_bolunen", div_bolunen, 0);
    chk("t6_resp_id", resp_id, 0);
    div_bitti = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset(); sif_rel = 1;
    wait_idle(100);               // stale done passes while idle
    base = gq.size();
    req(3, 8'h31, 8'h02); req(0, 8'h62, 8'h03);
    stub_lat = 4;
    wait_idle(100);
    chk("t6_first", (gq.size() > base) ? gq[base] : -1, 0);

    // randomized traffic
    s0 = served;
    rand_req = 1; rand_lat = 1; rdy_mode = 2;
    repeat (1500) tick();
    rand_req = 0; rdy_mode = 1;
    wait_idle(500);
    rand_lat = 0;
    chk("rand_served", served > s0 + 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
